repetition_encoder_tx: RTL and testbench

//   Transmit side of the 5-way majority-vote link. Accepts a parallel data word and

---
 rtl/rep_link_pkg.sv | 18 +
 rtl/rep_beat_counter.sv | 54 +++++
 rtl/repetition_encoder_tx.sv | 115 +++++++++++
 tb/tb_repetition_encoder_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rep_link_pkg.sv
// Shared types and helpers for the repetition-coded serial link (transmitter and voter).
// Define REP_PARITY_EN to append an even-parity bit to every frame.
package rep_link_pkg;

    typedef enum logic [0:0] {IDLE, SEND} rep_tx_state_t;

    localparam int REP_DEFAULT = 5;

    // Number of distinct bits carried per frame, including the optional parity bit.
    function automatic int nbits(input int data_w);
`ifdef REP_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

endpackage

// File: rtl/rep_beat_counter.sv
// Tracks which copy of which bit is on the wire; shared by the transmit and receive sides.
module rep_beat_counter #(
    parameter int REP   = 5,
    parameter int NBITS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic advance_i,
    output logic bit_done_o,
    output logic frame_done_o,
    output logic last_next_o
);

    localparam int RW = $clog2(REP);
    localparam int BW = $clog2(NBITS + 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          final_bit;

    assign final_bit    = (bit_cnt_q == BW'(NBITS - 1));
    assign bit_done_o   = (rep_cnt_q == RW'(REP - 1));
    assign frame_done_o = bit_done_o && final_bit;
    // True when the next advance lands on the final copy of the final bit.
    assign last_next_o  = (rep_cnt_q == RW'(REP - 2)) && final_bit;

    always_comb begin
        rep_cnt_d = rep_cnt_q;
        bit_cnt_d = bit_cnt_q;
        if (clear_i) begin
            rep_cnt_d = '0;
            bit_cnt_d = '0;
        end else if (advance_i) begin
            if (bit_done_o) begin
                rep_cnt_d = '0;
                bit_cnt_d = bit_cnt_q + BW'(1);
            end else begin
                rep_cnt_d = rep_cnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/repetition_encoder_tx.sv
// Serialises a word LSB first, sending each bit REP times for majority-vote recovery.
// Optional feature macro: REP_PARITY_EN (appends an even-parity bit as the last bit).
module repetition_encoder_tx
    import rep_link_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REP    = REP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int NBITS = nbits(DATA_W);

    generate
        if (REP < 3 || (REP % 2) == 0) begin : g_bad_rep
            $error("repetition_encoder_tx: REP must be odd and >= 3");
        end
        if (DATA_W < 1) begin : g_bad_width
            $error("repetition_encoder_tx: DATA_W must be >= 1");
        end
    endgenerate

    rep_tx_state_t    state_q;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [NBITS-1:0] load_word;
    logic             out_valid_q;
    logic             out_last_q;
    logic             accept;
    logic             beat;
    logic             bit_done;
    logic             frame_done;
    logic             last_next;

`ifdef REP_PARITY_EN
    assign load_word = {^in_data, in_data};
`else
    assign load_word = in_data;
`endif

    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign beat      = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_bit   = shreg_q[0];

    rep_beat_counter #(
        .REP   (REP),
        .NBITS (NBITS)
    ) u_beat_counter (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (accept),
        .advance_i    (beat),
        .bit_done_o   (bit_done),
        .frame_done_o (frame_done),
        .last_next_o  (last_next)
    );

    always_comb begin
        shreg_d = shreg_q;
        if (accept) begin
            shreg_d = load_word;
        end else if (beat && bit_done) begin
            shreg_d = shreg_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    // Completing the out_last beat drops back to IDLE, giving one bubble between frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= SEND;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                    end
                end
                SEND: begin
                    if (beat) begin
                        if (frame_done) begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            out_last_q  <= last_next;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_repetition_encoder_tx.sv
// Scoreboard bench for repetition_encoder_tx: an 8-bit/REP=5 instance and a 1-bit/REP=3 instance.
module tb_repetition_encoder_tx;

    localparam int DW  = 8;
    localparam int RP  = 5;
    localparam int DW1 = 1;
    localparam int RP1 = 3;
`ifdef REP_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB  = DW + PAR;
    localparam int NB1 = DW1 + PAR;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] inData;
    logic          inValid, inReady, outBit, outValid, outReady, outLast;
    logic [0:0]    inData1;
    logic          inValid1, inReady1, outBit1, outValid1, outReady1, outLast1;

    int         checkCount = 0;
    int         errorCount = 0;
    logic [1:0] sbQ[$];
    logic [1:0] sb1Q[$];
    int         beats = 0, beats1 = 0, accepts = 0, accepts1 = 0, idle1 = 0;
    logic       sawValid1 = 1'b0;
    logic       stallPending = 1'b0;
    logic       holdBit, holdLast;

    always #5 clk = ~clk;

    repetition_encoder_tx #(.DATA_W(DW), .REP(RP)) dut (
        .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_ready(inReady),
        .out_bit(outBit), .out_valid(outValid), .out_ready(outReady), .out_last(outLast)
    );

    repetition_encoder_tx #(.DATA_W(DW1), .REP(RP1)) dut1 (
        .clk(clk), .rst(rst), .in_data(inData1), .in_valid(inValid1), .in_ready(inReady1),
        .out_bit(outBit1), .out_valid(outValid1), .out_ready(outReady1), .out_last(outLast1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected {bit,last} for every beat of a frame.
    task automatic pushFrame(input int which, input logic [7:0] w, input int dw, input int rep);
        logic       p;
        logic [1:0] e;
        int         nb;
        nb = dw + PAR;
        p  = 1'b0;
        for (int i = 0; i < dw; i++) p = p ^ w[i];
        for (int b = 0; b < nb; b++) begin
            for (int r = 0; r < rep; r++) begin
                e[1] = (b < dw) ? w[b] : p;
                e[0] = (b == nb - 1) && (r == rep - 1);
                if (which == 0) sbQ.push_back(e);
                else            sb1Q.push_back(e);
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic rdy);
        logic [1:0] e;
        inValid  = v;
        inData   = d;
        outReady = rdy;
        @(negedge clk);
        if (!rst) begin
            checkOutput("ready_vs_valid", {31'd0, inReady}, {31'd0, !outValid});
            if (stallPending) begin
                checkOutput("stall_valid", {31'd0, outValid}, 32'd1);
                checkOutput("stall_bit", {31'd0, outBit}, {31'd0, holdBit});
                checkOutput("stall_last", {31'd0, outLast}, {31'd0, holdLast});
            end
            stallPending = 1'b0;
            if (inValid && inReady) begin
                pushFrame(0, inData, DW, RP);
                accepts++;
            end
            if (outValid && outReady) begin
                if (sbQ.size() == 0) begin
                    checkOutput("spurious_beat", {31'd0, outValid}, 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("beat_bit", {31'd0, outBit}, {31'd0, e[1]});
                    checkOutput("beat_last", {31'd0, outLast}, {31'd0, e[0]});
                end
                beats++;
            end else if (outValid) begin
                stallPending = 1'b1;
                holdBit      = outBit;
                holdLast     = outLast;
            end
            if (inValid1 && inReady1) begin
                pushFrame(1, {7'd0, inData1}, DW1, RP1);
                accepts1++;
            end
            if (outValid1) sawValid1 = 1'b1;
            if (!outValid1 && sawValid1 && sb1Q.size() > 0) idle1++;
            if (outValid1 && outReady1) begin
                if (sb1Q.size() == 0) begin
                    checkOutput("spurious_beat1", {31'd0, outValid1}, 32'd0);
                end else begin
                    e = sb1Q.pop_front();
                    checkOutput("beat1_bit", {31'd0, outBit1}, {31'd0, e[1]});
                    checkOutput("beat1_last", {31'd0, outLast1}, {31'd0, e[0]});
                end
                beats1++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sbQ.size() > 0 || sb1Q.size() > 0) && n < budget) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            n++;
        end
        checkOutput("drain_left", sbQ.size() + sb1Q.size(), 32'd0);
    endtask

    initial begin
        int base, n;
        rst = 1'b1; inValid = 1'b0; inData = '0; outReady = 1'b1;
        inValid1 = 1'b0; inData1 = '0; outReady1 = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("rst_out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("rst_out_last", {31'd0, outLast}, 32'd0);
        checkOutput("rst_out_bit", {31'd0, outBit}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, inReady}, 32'd0);
        checkOutput("rst_in_ready1", {31'd0, inReady1}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("in_ready_after_rst", {31'd0, inReady}, 32'd1);

        // Test 1: 0xA5 with the channel always ready.
        base = beats;
        applyStimulus(1'b1, 8'hA5, 1'b1);
        checkOutput("first_beat_valid", {31'd0, outValid}, 32'd1);
        checkOutput("first_beat_bit", {31'd0, outBit}, 32'd1);
        drain(200);
        checkOutput("t1_beats", beats - base, NB * RP);
        checkOutput("t1_valid_dropped", {31'd0, outValid}, 32'd0);
        checkOutput("t1_in_ready", {31'd0, inReady}, 32'd1);

        // Test 2: same word with a randomly stalling channel.
        base = beats;
        applyStimulus(1'b1, 8'hA5, 1'($urandom_range(0, 1)));
        n = 0;
        while (sbQ.size() > 0 && n < 1000) begin
            applyStimulus(1'b0, 8'h00, 1'($urandom_range(0, 1)));
            n++;
        end
        drain(200);
        checkOutput("t2_beats", beats - base, NB * RP);

        // Test 3: 0xFF held on the input while 0x00 is in flight.
        base = accepts;
        applyStimulus(1'b1, 8'h00, 1'b1);
        n = 0;
        while (accepts < base + 2 && n < 200) begin
            applyStimulus(1'b1, 8'hFF, 1'b1);
            n++;
        end
        checkOutput("t3_accepts", accepts - base, 32'd2);
        checkOutput("t3_gap_cycles", n, NB * RP + 1);
        drain(200);

        // Test 4: reset after 17 accepted beats, then a fresh word.
        base = beats;
        applyStimulus(1'b1, 8'h5A, 1'b1);
        n = 0;
        while (beats < base + 17 && n < 200) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            n++;
        end
        checkOutput("t4_beats_before_rst", beats - base, 32'd17);
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t4_out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("t4_out_last", {31'd0, outLast}, 32'd0);
        checkOutput("t4_in_ready", {31'd0, inReady}, 32'd0);
        sbQ.delete();
        stallPending = 1'b0;
        rst = 1'b0;
        base = beats;
        applyStimulus(1'b1, 8'h3C, 1'b1);
        drain(200);
        checkOutput("t4_new_frame_beats", beats - base, NB * RP);

        // Test 5: words whose parity differs (parity beats only with REP_PARITY_EN).
        applyStimulus(1'b1, 8'h07, 1'b1);
        drain(200);
        applyStimulus(1'b1, 8'h03, 1'b1);
        drain(200);

        // Test 6: 1-bit words back to back on the narrow instance.
        base      = beats1;
        n         = accepts1;
        idle1     = 0;
        sawValid1 = 1'b0;
        inValid1  = 1'b1;
        inData1   = 1'b1;
        for (int k = 0; k < 2 * (NB1 * RP1 + 1); k++) applyStimulus(1'b0, 8'h00, 1'b1);
        inValid1 = 1'b0;
        drain(200);
        checkOutput("t6_accepts", accepts1 - n, 32'd2);
        checkOutput("t6_beats", beats1 - base, 2 * NB1 * RP1);
        checkOutput("t6_idle_between", idle1, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
